// File: rtl/counter_pkg.sv
// Shared types for the modal counter: terminal-count modes and the
// run/done state of the one-shot machine.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: produces one tick per (reload_i + 1) enabled cycles.
// The tick is a combinational decode of the prescaler register so the
// parent consumes it on the same edge. If reload_i is lowered below the
// current count, the count runs on to all-ones and the tick fires there.
module counter_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] reload_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] cnt_r;
    logic                  at_max_s;

    assign at_max_s = (cnt_r == {PRESCALE_W{1'b1}});
    assign tick_o   = en_i && ((cnt_r == reload_i) || at_max_s);

    // Prescaler count: restart on reset, clear or tick, advance when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_r <= {PRESCALE_W{1'b0}};
        end else if (tick_o) begin
            cnt_r <= {PRESCALE_W{1'b0}};
        end else if (en_i) begin
            cnt_r <= cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/modal_counter.sv
// Modal counter: programmable step, limit and prescaler with wrap,
// saturate and one-shot terminal behaviour. All outputs are registered.
module modal_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STEP_W     = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic                  load_i,
    input  logic                  down_i,
    input  logic [1:0]            mode_i,
    input  logic [STEP_W-1:0]     step_i,
    input  logic [WIDTH-1:0]      limit_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [WIDTH-1:0]      d_i,
    output logic [WIDTH-1:0]      q_o,
    output logic                  tick_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  sat_o,
    output logic                  done_o
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic             tick_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             sat_r;
    logic             done_r;
    state_e           state_r;

    logic             presc_en_s;
    logic             presc_clear_s;
    logic             presc_tick_s;

    mode_e            mode_s;
    logic             is_wrap_s;
    logic [WIDTH:0]   lim1_s;
    logic [WIDTH:0]   step_ext_s;
    logic [WIDTH:0]   step_mod_s;
    logic [WIDTH:0]   step_use_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] q_next_s;
    logic             ovf_next_s;
    logic             unf_next_s;
    logic             sat_next_s;
    logic             done_next_s;
    state_e           state_next_s;

    // Prescaler is frozen in DONE; load restarts it just like clear.
    assign presc_en_s    = en_i && (state_r == ST_RUN);
    assign presc_clear_s = clear_i || load_i;

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (presc_clear_s),
        .en_i     (presc_en_s),
        .reload_i (prescale_i),
        .tick_o   (presc_tick_s)
    );

    // Next count and flag values should the current cycle carry a tick.
    always_comb begin
        mode_s       = mode_e'(mode_i);
        is_wrap_s    = (mode_s == MODE_WRAP) || (mode_s == MODE_RSVD);
        lim1_s       = {1'b0, limit_i} + {{WIDTH{1'b0}}, 1'b1};
        step_ext_s   = {{(WIDTH+1-STEP_W){1'b0}}, step_i};
        // Oversized steps only make sense modulo the range when wrapping.
        step_mod_s   = step_ext_s % lim1_s;
        step_use_s   = is_wrap_s ? step_mod_s : step_ext_s;
        sum_s        = {1'b0, q_r} + step_use_s;
        q_next_s     = q_r;
        ovf_next_s   = 1'b0;
        unf_next_s   = 1'b0;
        sat_next_s   = 1'b0;
        done_next_s  = done_r;
        state_next_s = state_r;
        if (!down_i) begin
            if (sum_s > {1'b0, limit_i}) begin
                case (mode_s)
                    MODE_SAT: begin
                        q_next_s   = limit_i;
                        ovf_next_s = !(sat_r && (q_r == limit_i));
                        sat_next_s = 1'b1;
                    end
                    MODE_ONESHOT: begin
                        q_next_s     = limit_i;
                        ovf_next_s   = 1'b1;
                        done_next_s  = 1'b1;
                        state_next_s = ST_DONE;
                    end
                    default: begin
                        q_next_s   = q_r + step_use_s[WIDTH-1:0] - limit_i - ONE_W;
                        ovf_next_s = 1'b1;
                    end
                endcase
            end else begin
                q_next_s   = sum_s[WIDTH-1:0];
                // A zero step leaves a pinned counter on its bound.
                sat_next_s = (mode_s == MODE_SAT) && sat_r && (sum_s[WIDTH-1:0] == q_r);
            end
        end else begin
            if (step_use_s <= {1'b0, q_r}) begin
                q_next_s   = q_r - step_use_s[WIDTH-1:0];
                sat_next_s = (mode_s == MODE_SAT) && sat_r && (step_use_s == {(WIDTH+1){1'b0}});
            end else begin
                case (mode_s)
                    MODE_SAT: begin
                        q_next_s   = {WIDTH{1'b0}};
                        unf_next_s = !(sat_r && (q_r == {WIDTH{1'b0}}));
                        sat_next_s = 1'b1;
                    end
                    MODE_ONESHOT: begin
                        q_next_s     = {WIDTH{1'b0}};
                        unf_next_s   = 1'b1;
                        done_next_s  = 1'b1;
                        state_next_s = ST_DONE;
                    end
                    default: begin
                        q_next_s   = q_r + limit_i + ONE_W - step_use_s[WIDTH-1:0];
                        unf_next_s = 1'b1;
                    end
                endcase
            end
        end
    end

    // Count, flag and RUN/DONE state register with reset > clear > load > tick.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            q_r         <= {WIDTH{1'b0}};
            tick_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            sat_r       <= 1'b0;
            done_r      <= 1'b0;
            state_r     <= ST_RUN;
        end else if (load_i) begin
            q_r         <= (d_i > limit_i) ? limit_i : d_i;
            tick_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            sat_r       <= 1'b0;
            done_r      <= 1'b0;
            state_r     <= ST_RUN;
        end else if (presc_tick_s) begin
            q_r         <= q_next_s;
            tick_r      <= 1'b1;
            overflow_r  <= ovf_next_s;
            underflow_r <= unf_next_s;
            sat_r       <= sat_next_s;
            done_r      <= done_next_s;
            state_r     <= state_next_s;
        end else begin
            tick_r      <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end
    end

    assign q_o         = q_r;
    assign tick_o      = tick_r;
    assign overflow_o  = overflow_r;
    assign underflow_o = underflow_r;
    assign sat_o       = sat_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_modal_counter.sv
// Self-checking bench for modal_counter: each scenario pushes the expected
// output vector {q, tick, overflow, underflow, sat, done} when it drives a
// cycle and pops/compares it once the DUT has produced that cycle's result.
module tb_modal_counter;

    localparam int WIDTH      = 8;
    localparam int STEP_W     = 4;
    localparam int PRESCALE_W = 8;
    localparam int VW         = WIDTH + 5;

    typedef logic [VW-1:0] vec_t;

    logic                  clk;
    logic                  rst_i;
    logic                  clear_i;
    logic                  en_i;
    logic                  load_i;
    logic                  down_i;
    logic [1:0]            mode_i;
    logic [STEP_W-1:0]     step_i;
    logic [WIDTH-1:0]      limit_i;
    logic [PRESCALE_W-1:0] prescale_i;
    logic [WIDTH-1:0]      d_i;
    logic [WIDTH-1:0]      q_o;
    logic                  tick_o;
    logic                  overflow_o;
    logic                  underflow_o;
    logic                  sat_o;
    logic                  done_o;

    vec_t obs;
    vec_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    assign obs = {q_o, tick_o, overflow_o, underflow_o, sat_o, done_o};

    modal_counter #(
        .WIDTH      (WIDTH),
        .STEP_W     (STEP_W),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .en_i        (en_i),
        .load_i      (load_i),
        .down_i      (down_i),
        .mode_i      (mode_i),
        .step_i      (step_i),
        .limit_i     (limit_i),
        .prescale_i  (prescale_i),
        .d_i         (d_i),
        .q_o         (q_o),
        .tick_o      (tick_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .sat_o       (sat_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [WIDTH-1:0] q, input logic t, input logic o,
                                input logic u, input logic s, input logic d);
        return {q, t, o, u, s, d};
    endfunction

    task automatic pulses_off();
        rst_i   = 1'b0;
        clear_i = 1'b0;
        load_i  = 1'b0;
        en_i    = 1'b0;
    endtask

    task automatic test_reset();
        vec_t e;
        vec_t tab [6];
        tab = '{mk(8'd0, 0, 0, 0, 0, 0), mk(8'd37, 0, 0, 0, 0, 0), mk(8'd0, 0, 0, 0, 0, 0),
                mk(8'd1, 1, 0, 0, 0, 0), mk(8'd2, 1, 0, 0, 0, 0), mk(8'd2, 0, 0, 0, 0, 0)};
        mode_i = 2'd0; limit_i = 8'd255; prescale_i = 8'd0; step_i = 4'd1; down_i = 1'b0; d_i = 8'd0;
        for (int i = 0; i < 6; i++) begin
            pulses_off();
            case (i)
                0:       rst_i = 1'b1;
                1:       begin load_i = 1'b1; d_i = 8'd37; end
                2:       begin rst_i = 1'b1; en_i = 1'b1; end
                3, 4:    en_i = 1'b1;
                default: en_i = 1'b0;
            endcase
            sb.push_back(tab[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got q=%0d flags(t,o,u,s,d)=%b expected q=%0d flags=%b",
                         i, obs[VW-1:5], obs[4:0], e[VW-1:5], e[4:0]);
            end
        end
    endtask

    task automatic test_wrap_up();
        vec_t e;
        vec_t tab [6];
        tab = '{mk(8'd0, 0, 0, 0, 0, 0), mk(8'd3, 1, 0, 0, 0, 0), mk(8'd6, 1, 0, 0, 0, 0),
                mk(8'd9, 1, 0, 0, 0, 0), mk(8'd2, 1, 1, 0, 0, 0), mk(8'd2, 0, 0, 0, 0, 0)};
        mode_i = 2'd0; limit_i = 8'd9; prescale_i = 8'd0; step_i = 4'd3; down_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulses_off();
            if (i == 0) clear_i = 1'b1;
            else        en_i = (i < 5);
            sb.push_back(tab[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL wrap_up[%0d]: got q=%0d flags(t,o,u,s,d)=%b expected q=%0d flags=%b",
                         i, obs[VW-1:5], obs[4:0], e[VW-1:5], e[4:0]);
            end
        end
    endtask

    task automatic test_sat_down();
        vec_t e;
        vec_t tab [6];
        tab = '{mk(8'd6, 0, 0, 0, 0, 0), mk(8'd2, 1, 0, 0, 0, 0), mk(8'd0, 1, 0, 1, 1, 0),
                mk(8'd0, 1, 0, 0, 1, 0), mk(8'd4, 1, 0, 0, 0, 0), mk(8'd4, 0, 0, 0, 0, 0)};
        mode_i = 2'd1; limit_i = 8'd200; prescale_i = 8'd0; step_i = 4'd4; d_i = 8'd6;
        for (int i = 0; i < 6; i++) begin
            pulses_off();
            down_i = (i < 4);
            if (i == 0) load_i = 1'b1;
            else        en_i = (i < 5);
            sb.push_back(tab[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL sat_down[%0d]: got q=%0d flags(t,o,u,s,d)=%b expected q=%0d flags=%b",
                         i, obs[VW-1:5], obs[4:0], e[VW-1:5], e[4:0]);
            end
        end
    endtask

    task automatic test_oneshot();
        vec_t e;
        vec_t x;
        logic [WIDTH-1:0] q;
        mode_i = 2'd2; limit_i = 8'd5; prescale_i = 8'd2; step_i = 4'd2; down_i = 1'b0;
        for (int i = -1; i < 20; i++) begin
            pulses_off();
            if (i == -1) begin
                load_i = 1'b1; d_i = 8'd0; x = mk(8'd0, 0, 0, 0, 0, 0);
            end else if (i == 19) begin
                load_i = 1'b1; d_i = 8'd1; en_i = 1'b1; x = mk(8'd1, 0, 0, 0, 0, 0);
            end else if (i >= 9) begin
                en_i = 1'b1; x = mk(8'd5, 0, 0, 0, 0, 1);
            end else begin
                en_i = 1'b1;
                q = (i >= 8) ? 8'd5 : (i >= 5) ? 8'd4 : (i >= 2) ? 8'd2 : 8'd0;
                x = mk(q, (i == 2) || (i == 5) || (i == 8), i == 8, 1'b0, 1'b0, i == 8);
            end
            sb.push_back(x);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL oneshot[%0d]: got q=%0d flags(t,o,u,s,d)=%b expected q=%0d flags=%b",
                         i, obs[VW-1:5], obs[4:0], e[VW-1:5], e[4:0]);
            end
        end
    endtask

    task automatic test_priority();
        vec_t e;
        vec_t tab [4];
        tab = '{mk(8'd10, 0, 0, 0, 0, 0), mk(8'd0, 0, 0, 0, 0, 0),
                mk(8'd100, 0, 0, 0, 0, 0), mk(8'd0, 1, 1, 0, 0, 0)};
        mode_i = 2'd0; limit_i = 8'd255; prescale_i = 8'd0; step_i = 4'd1; down_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulses_off();
            case (i)
                0:       begin load_i = 1'b1; d_i = 8'd10; end
                1:       begin en_i = 1'b1; clear_i = 1'b1; load_i = 1'b1; d_i = 8'd77; end
                2:       begin en_i = 1'b1; load_i = 1'b1; d_i = 8'd250; limit_i = 8'd100; end
                default: en_i = 1'b1;
            endcase
            sb.push_back(tab[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL priority[%0d]: got q=%0d flags(t,o,u,s,d)=%b expected q=%0d flags=%b",
                         i, obs[VW-1:5], obs[4:0], e[VW-1:5], e[4:0]);
            end
        end
    endtask

    task automatic test_limit_drop();
        vec_t e;
        vec_t tab [6];
        tab = '{mk(8'd50, 0, 0, 0, 0, 0), mk(8'd30, 1, 1, 0, 0, 0), mk(8'd30, 0, 0, 0, 0, 0),
                mk(8'd254, 0, 0, 0, 0, 0), mk(8'd1, 1, 1, 0, 0, 0), mk(8'd254, 1, 0, 1, 0, 0)};
        mode_i = 2'd0; prescale_i = 8'd0; step_i = 4'd1; down_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulses_off();
            case (i)
                0:       begin limit_i = 8'd255; load_i = 1'b1; d_i = 8'd50; end
                1:       begin limit_i = 8'd20; en_i = 1'b1; end
                2:       en_i = 1'b0;
                3:       begin limit_i = 8'd255; mode_i = 2'd3; load_i = 1'b1; d_i = 8'd254; end
                4:       begin en_i = 1'b1; step_i = 4'd3; end
                default: begin en_i = 1'b1; down_i = 1'b1; end
            endcase
            sb.push_back(tab[i]);
            @(posedge clk); #1;
            e = sb.pop_front(); vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL limit_drop[%0d]: got q=%0d flags(t,o,u,s,d)=%b expected q=%0d flags=%b",
                         i, obs[VW-1:5], obs[4:0], e[VW-1:5], e[4:0]);
            end
        end
    endtask

    initial begin
        pulses_off();
        down_i = 1'b0; mode_i = 2'd0; step_i = 4'd0; limit_i = 8'd255;
        prescale_i = 8'd0; d_i = 8'd0;
        @(negedge clk);
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_oneshot();
        test_priority();
        test_limit_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/modal_counter.md
Name: modal_counter

Overview:
- Next-generation counter for the timer/event-count subsystem, replacing the fixed 4-bit up/down counter.
- Parametrised width, programmable step and programmable terminal limit.
- Enable prescaler and three terminal-count modes: wrap, saturate, one-shot.
- Sits behind control logic that drives clear/load/enable and consumes pulse flags.

Parameters:
- WIDTH, 8, counter and limit width (>=2).
- STEP_W, 4, width of step_i (<= WIDTH).
- PRESCALE_W, 8, width of prescaler reload; count advances once per (prescale_i+1) enabled cycles.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- clear_i  input  1  force count, prescaler and flags to zero.
- en_i  input  1  prescaler/count enable.
- load_i  input  1  load d_i.
- down_i  input  1  1=count down, 0=count up; sampled on each tick.
- mode_i  input  2  terminal mode (counter_pkg::mode_e).
- step_i  input  STEP_W  increment per tick; 0 = hold.
- limit_i  input  WIDTH  terminal value; valid count range 0..limit_i.
- prescale_i  input  PRESCALE_W  prescaler reload.
- d_i  input  WIDTH  load value.
- q_o  output  WIDTH  registered count.
- tick_o  output  1  registered pulse: a count tick occurred last cycle.
- overflow_o  output  1  registered one-cycle pulse: up count crossed limit_i.
- underflow_o  output  1  registered one-cycle pulse: down count crossed 0.
- sat_o  output  1  registered level: counter is pinned at a bound (saturate mode).
- done_o  output  1  registered sticky: one-shot terminated.

Behaviour:
- Reset is synchronous: on the edge with rst_i=1, q_o=0, prescaler=0, tick_o/overflow_o/underflow_o=0, sat_o=0, done_o=0, state=RUN.
- Priority, highest first: rst_i > clear_i > load_i > count tick.
- clear_i: same values as reset. Takes effect regardless of en_i.
- load_i:
  - q <= min(d_i, limit_i).
  - prescaler <= 0; sat_o, done_o <= 0; state <= RUN.
  - No pulses are generated.
- Prescaler:
  - Advances only when en_i=1 and state=RUN.
  - Tick fires when prescaler==prescale_i, then prescaler <= 0.
  - prescale_i=0 gives a tick on every enabled cycle.
  - If prescale_i is lowered below the current prescaler value, the tick fires when the prescaler reaches its max and wraps.
- Latency: q_o and all flags update on the edge that consumes the tick, i.e. the cycle after the tick condition. tick_o asserts in the same cycle as the q_o update.
- Up tick: compute sum = q + step at WIDTH+1 bits.
  - sum <= limit_i: q <= sum.
  - sum > limit_i, WRAP: q <= sum - limit_i - 1; overflow_o pulse.
  - sum > limit_i, SAT: q <= limit_i; overflow_o pulse only on the first pinning tick; sat_o <= 1.
  - sum > limit_i, ONESHOT: q <= limit_i; overflow_o pulse; done_o <= 1; state <= DONE.
- Down tick:
  - step <= q: q <= q - step.
  - Otherwise WRAP: q <= q + limit_i + 1 - step; underflow_o pulse.
  - Otherwise SAT: q <= 0; underflow_o pulse only on the first pinning tick; sat_o <= 1.
  - Otherwise ONESHOT: q <= 0; underflow_o pulse; done_o <= 1; state <= DONE.
- sat_o clears on a tick that moves q off the bound, and on clear_i or load_i.
- Step constraint: defined for step_i <= limit_i+1. Larger values in WRAP mode are reduced modulo (limit_i+1).
- q > limit_i (after limit_i is lowered at runtime):
  - Up tick is treated as overflow.
  - Down tick subtracts normally.
- State machine: RUN <-> DONE.
  - DONE: q and prescaler frozen, en_i ignored.
  - Exit DONE only via rst_i, clear_i or load_i.
- mode_i=2'b11 (reserved) behaves as WRAP.
- A mode_i change takes effect on the next tick. Changing away from SAT clears sat_o on that tick.
- Simultaneous load_i and tick: load wins, tick discarded, no pulse.
- limit_i = all-ones: full-range modular counter; overflow_o marks the natural carry.

Decomposition:
- counter_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_WRAP=0, MODE_SAT=1, MODE_ONESHOT=2, MODE_RSVD=3}.
  - typedef enum logic state_e {ST_RUN, ST_DONE}.
- Sub-module counter_prescaler (clk_i, rst_i, clear_i, en_i, reload_i, tick_o): isolates the prescaler.
- modal_counter holds the step arithmetic, mode handling and flags.

Test Plan (WIDTH=8, STEP_W=4):
- Reset mid-count: q_o=37, rst_i=1 for one cycle -> next cycle q_o=0, all flags 0; counting resumes from 0 once en_i=1.
- WRAP up, limit_i=9, step_i=3, prescale_i=0, start 0 -> q_o sequence 3,6,9,2; overflow_o pulses only with q_o=2.
- SAT down, limit_i=200, step_i=4, load 6 -> q_o 2,0,0; underflow_o pulses exactly once; sat_o=1 from the first 0; an up tick then gives q_o=4 and sat_o=0.
- ONESHOT up, limit_i=5, step_i=2, prescale_i=2 -> q_o changes every 3 enabled cycles: 2,4,5; done_o=1 and q_o stays 5 with en_i=1 for 10 cycles; load_i with d_i=1 -> q_o=1, done_o=0.
- Priority: clear_i and load_i together with a pending tick -> q_o=0, no pulse. load_i with d_i=250, limit_i=100 -> q_o=100.
- Runtime limit drop: q_o=50, limit_i changed to 20, WRAP up with step_i=1 -> next q_o = 51-20-1 = 30; overflow_o pulses.
